// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// One bit is processed per cycle; signed ops work on magnitudes and fix up the sign at the end.
module mult_div_unit #(
   parameter int CYCLES = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic        WriteHi,
   input  logic        WriteLo,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam int CW = $clog2(CYCLES);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          isDiv_q;
   logic          signA_q;
   logic          signB_q;
   logic [31:0]   magA_q;
   logic [31:0]   magB_q;
   logic [63:0]   acc_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          busy_q;
   logic          done_q;
   logic          dbz_q;

   logic          signA_d;
   logic          signB_d;
   logic [31:0]   magA_d;
   logic [31:0]   magB_d;

   logic [32:0]   addSum;
   logic [32:0]   remShift;
   logic [31:0]   remDiff;
   logic [63:0]   accIter;
   logic [63:0]   prodFix;
   logic [31:0]   hiFix;
   logic [31:0]   loFix;
   logic          dbzFix;

   // Op[0]=0 selects the signed variants (MULT/DIV); unsigned ops keep raw operands.
   always_comb begin
      signA_d = ~Op[0] & OpA[31];
      signB_d = ~Op[0] & OpB[31];
      magA_d  = signA_d ? -OpA : OpA;
      magB_d  = signB_d ? -OpB : OpB;
   end

   // Multiply: acc holds {partial product, remaining multiplier bits}.
   // Divide: acc holds {remainder, dividend bits shifting out / quotient bits shifting in}.
   always_comb begin
      addSum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? magA_q : 32'd0)};
      remShift = {acc_q[63:32], acc_q[31]};
      remDiff  = remShift[31:0] - magB_q;
      if (isDiv_q) begin
         if (remShift >= {1'b0, magB_q}) begin
            accIter = {remDiff, acc_q[30:0], 1'b1};
         end else begin
            accIter = {remShift[31:0], acc_q[30:0], 1'b0};
         end
      end else begin
         accIter = {addSum, acc_q[31:1]};
      end
   end

   always_comb begin
      prodFix = (signA_q ^ signB_q) ? -acc_q : acc_q;
      hiFix   = prodFix[63:32];
      loFix   = prodFix[31:0];
      dbzFix  = 1'b0;
      if (isDiv_q) begin
         if (magB_q == 32'd0) begin
            // Hand back the original dividend so software can inspect it.
            loFix  = 32'hFFFF_FFFF;
            hiFix  = signA_q ? -magA_q : magA_q;
            dbzFix = 1'b1;
         end else begin
            loFix  = (signA_q ^ signB_q) ? -acc_q[31:0] : acc_q[31:0];
            hiFix  = signA_q ? -acc_q[63:32] : acc_q[63:32];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         isDiv_q <= 1'b0;
         signA_q <= 1'b0;
         signB_q <= 1'b0;
         magA_q  <= '0;
         magB_q  <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // Start takes priority over a same-cycle MTHI/MTLO.
               if (Start) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  isDiv_q <= Op[1];
                  signA_q <= signA_d;
                  signB_q <= signB_d;
                  magA_q  <= magA_d;
                  magB_q  <= magB_d;
                  acc_q   <= {32'd0, (Op[1] ? magA_d : magB_d)};
               end else begin
                  if (WriteHi) hi_q <= WriteData;
                  if (WriteLo) lo_q <= WriteData;
               end
            end
            CALC: begin
               acc_q <= accIter;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(CYCLES - 1)) state_q <= FIX;
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               dbz_q   <= dbzFix;
               hi_q    <= hiFix;
               lo_q    <= loFix;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign DivByZero = dbz_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner
// sequences and randomized operations checked against a plain-arithmetic model.
module tb_mult_div_unit;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] OpA;
   logic [31:0] OpB;
   logic        WriteHi;
   logic        WriteLo;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] curHi = 32'd0;
   logic [31:0] curLo = 32'd0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      bit          noise;
   } vec_t;

   vec_t vecs[8];

   mult_div_unit #(.CYCLES(32)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: full-width arithmetic; returns {dbz, hi, lo}.
   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] r64;
      logic [63:0]        p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         2'b00: begin p = sa * sb; return {1'b0, p}; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
         2'b10: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            p   = sa / sb;
            r64 = sa % sb;
            return {1'b0, r64[31:0], p[31:0]};
         end
         default: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz,
                                input bit noise, input bit wrLo, input string tag);
      int n;
      bit stableBad;
      Op = op; OpA = a; OpB = b; Start = 1'b1;
      WriteLo = wrLo; WriteData = 32'hDEAD_BEEF;
      tick();
      Start = 1'b0; WriteLo = 1'b0;
      checkOutput({tag, ".busy"}, 32'(Busy), 32'd1);
      n = 0;
      stableBad = 1'b0;
      while (!Done && n < 40) begin
         if (Hi !== curHi || Lo !== curLo) stableBad = 1'b1;
         if (noise) begin
            OpA = $urandom; OpB = $urandom; Start = 1'($urandom);
            WriteHi = 1'($urandom); WriteLo = 1'($urandom); WriteData = $urandom;
         end
         tick();
         n++;
      end
      Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
      checkOutput({tag, ".latency"}, 32'(n), 32'd33);
      checkOutput({tag, ".busyDone"}, 32'(Busy), 32'd0);
      checkOutput({tag, ".stable"}, 32'(stableBad), 32'd0);
      checkOutput({tag, ".hi"}, Hi, expHi);
      checkOutput({tag, ".lo"}, Lo, expLo);
      checkOutput({tag, ".dbz"}, 32'(DivByZero), 32'(expDbz));
      curHi = expHi;
      curLo = expLo;
   endtask

   task automatic runModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit noise, input string tag);
      logic [64:0] m;
      m = model(op, a, b);
      applyStimulus(op, a, b, m[63:32], m[31:0], m[64], noise, 1'b0, tag);
   endtask

   initial begin
      int  n;
      bit  sawDone;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0};
      vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b1};
      vecs[4] = '{2'b11, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0};
      vecs[6] = '{2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, 1'b1};
      vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};

      Rst = 1'b0; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
      WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
      tick();
      tick();
      Rst = 1'b1;
      checkOutput("reset.hi", Hi, 32'd0);
      checkOutput("reset.lo", Lo, 32'd0);
      checkOutput("reset.busy", 32'(Busy), 32'd0);
      checkOutput("reset.done", 32'(Done), 32'd0);
      checkOutput("reset.dbz", 32'(DivByZero), 32'd0);

      // MTHI/MTLO together, then MTHI alone.
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hA5A5_A5A5;
      tick();
      WriteLo = 1'b0; WriteData = 32'h1111_1111;
      checkOutput("mtBoth.hi", Hi, 32'hA5A5_A5A5);
      checkOutput("mtBoth.lo", Lo, 32'hA5A5_A5A5);
      tick();
      WriteHi = 1'b0;
      checkOutput("mthi.hi", Hi, 32'h1111_1111);
      checkOutput("mthi.lo", Lo, 32'hA5A5_A5A5);
      curHi = 32'h1111_1111;
      curLo = 32'hA5A5_A5A5;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                       vecs[i].noise, 1'b0, $sformatf("vec%0d", i));
      end

      tick();
      checkOutput("donePulse.done", 32'(Done), 32'd0);
      checkOutput("donePulse.dbz", 32'(DivByZero), 32'd0);

      // Back-to-back: second Start is issued in the Done cycle of the first.
      runModel(2'b01, 32'd1000, 32'd3000, 1'b0, "b2b0");
      runModel(2'b11, 32'd1000, 32'd33, 1'b0, "b2b1");

      // Start with MTLO in the same cycle: the write is dropped.
      tick();
      applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1, "startWrLo");

      // Abort a MULT by reset after an ignored Start/MTHI during CALC.
      tick();
      Op = 2'b00; OpA = 32'd3; OpB = 32'd5; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      Start = 1'b1; WriteHi = 1'b1; WriteData = 32'h0000_1234;
      tick();
      Start = 1'b0; WriteHi = 1'b0;
      checkOutput("abort.ignoredWrite", Hi, curHi);
      for (int i = 0; i < 3; i++) tick();
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      checkOutput("abort.hi", Hi, 32'd0);
      checkOutput("abort.lo", Lo, 32'd0);
      checkOutput("abort.busy", 32'(Busy), 32'd0);
      sawDone = 1'b0;
      for (n = 0; n < 40; n++) begin
         if (Done || Busy) sawDone = 1'b1;
         tick();
      end
      checkOutput("abort.noDone", 32'(sawDone), 32'd0);
      curHi = 32'd0;
      curLo = 32'd0;
      applyStimulus(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0, "afterAbort");

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         runModel(rop, ra, rb, 1'(i), $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO.
- Operand B is the output of the EX-stage 32-bit 2:1 operand mux (register vs. immediate). Operand A is the rs value.
- The hazard unit stalls the pipeline while Busy is high.

Parameters:
- CYCLES, 32, number of iteration cycles; must equal the operand width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous reset, active-low.
- Start  input  1  launch operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OpA  input  32  multiplicand / dividend (rs).
- OpB  input  32  multiplier / divisor (operand-mux output).
- WriteHi  input  1  MTHI write enable.
- WriteLo  input  1  MTLO write enable.
- WriteData  input  32  MTHI/MTLO data.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Hi/Lo hold a new result.
- DivByZero  output  1  one-cycle pulse with Done for DIV/DIVU with OpB=0.
- Hi  output  32  HI register.
- Lo  output  32  LO register.

Behaviour:
- Reset: Rst=0 at a rising edge gives state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, counter=0. Reset mid-operation aborts the operation; no partial result is written.
- States:
  - IDLE to CALC on Start=1.
  - CALC to FIX after CYCLES iterations.
  - FIX to IDLE unconditionally; Hi/Lo are written on this transition.
- Latching at Start edge (edge k): Op, sign flags, and |OpA|, |OpB| are captured. Magnitudes are taken only for signed ops (MULT/DIV); unsigned ops use raw values. OpA/OpB changes after edge k are ignored.
- CALC, one bit per cycle, counter 0..31:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division with a 32-bit remainder and quotient shift.
- FIX (edge k+33):
  - MULT: negate the 64-bit product if sign(A) ≠ sign(B).
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Multiply: Hi=product[63:32], Lo=product[31:0].
  - Divide: Hi=remainder, Lo=quotient.
  - Done=1 and DivByZero as applicable, for exactly the cycle after edge k+33.
- Timing: Busy=1 from after edge k through edge k+33, and is 0 in the Done cycle. A back-to-back Start is legal in the Done cycle.
- Divide by zero: full latency retained. Lo=0xFFFFFFFF, Hi=original OpA (unsigned and signed), DivByZero=1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0x00000000, no flag.
- Start while Busy: ignored, with no effect on the running operation.
- WriteHi/WriteLo:
  - In IDLE, the register is updated with WriteData at the next edge; both may be asserted together.
  - While Busy, ignored.
  - If Start and a write arrive in the same IDLE cycle, Start wins and the write is dropped.
- Hi/Lo are stable except at the FIX edge, MTHI/MTLO writes, and reset. Reads (MFHI/MFLO) are combinational from the registers.

Test Plan:
- MULTU OpA=0xFFFFFFFF, OpB=0xFFFFFFFF, Start at edge k -> Busy 33 cycles; Done at cycle k+34; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT OpA=0xFFFFFFFD (-3), OpB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; operands changed mid-CALC do not alter the result.
- DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU OpA=100, OpB=7 -> Lo=14, Hi=2.
- DIVU OpA=0x64, OpB=0 -> Lo=0xFFFFFFFF, Hi=0x64, DivByZero=1 with Done. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start a MULT, pulse Start and WriteHi (0x1234) at cycle 5 of CALC, then Rst=0 at cycle 10 -> Hi=Lo=0, Busy=0, no Done. The following MULTU 6×7 gives Lo=42, Hi=0.
- IDLE: WriteHi=1, WriteLo=1, WriteData=0xA5A5A5A5 -> Hi=Lo=0xA5A5A5A5. Start plus WriteLo in the same cycle -> write dropped, operation result stored.
